mult4bit_asmd_top: RTL and testbench
====================================

Name: mult4bit_asmd_top

Overview:
- Sequential unsigned shift-and-add multiplier, controlled by an ASMD-style FSM.
- Accepts two M-bit operands on a start pulse, iterates one multiplier bit per clock, and registers the 2M-bit product on output S.
- Standalone arithmetic block for datapaths that can tolerate multi-cycle latency in exchange for small area.

Parameters:
- M, default 4: operand width in bits. The product is 2*M bits. Legal range is M >= 2. The bench uses M=5.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset; one clock, reset is asynchronous and active-high (port named reset_n per codebase naming; asserted = 1).
- A_in  in  M  multiplicand, unsigned.
- B_in  in  M  multiplier, unsigned.
- start  in  1  request; sampled only in IDLE.
- S  out  2*M  registered product, unsigned.

Behaviour:
- Reset (asynchronous, reset_n=1):
  - FSM goes to IDLE.
  - S, accumulator, multiplicand register, multiplier register and counter all clear to 0.
- Reset mid-operation aborts immediately. S becomes 0. No partial result is ever published.
- States: IDLE, CALC, DONE.
- IDLE:
  - S holds its last value.
  - If start=1 at a rising edge: latch A_in into the multiplicand register, latch B_in into the multiplier register, clear the accumulator, load counter=M, go to CALC.
  - Operands are sampled only on this edge; later changes to A_in/B_in are ignored.
- CALC, one iteration per clock:
  - If multiplier LSB=1, add the multiplicand into the upper M bits of the accumulator with carry-out kept (M+1-bit add).
  - Shift {carry, accumulator, multiplier} right by 1.
  - Decrement the counter. When the counter reaches 0 after this iteration, go to DONE.
  - Exactly M CALC cycles.
- DONE: S <= final 2M-bit product (A*B, exact, no overflow possible); go to IDLE.
- Latency: with start sampled at edge k, S is valid after edge k+M+1 (edge k+6 for M=5).
- A new start is accepted at the first IDLE edge after DONE. Back-to-back issue interval is M+2 cycles.
- start asserted in CALC or DONE is ignored; it is not queued.
- start held high continuously re-launches on every IDLE edge.
- Zero operand: full M iterations still run and the result is 0.
- Width rule: all arithmetic is unsigned. The max result (2^M-1)^2 fits in 2M bits.

Optional Feature:
- Macro MULT_DONE_EN.
- Defined:
  - Adds output port done (1 bit), registered, reset 0.
  - done pulses high for exactly one cycle, in the same cycle S first shows the new product (the cycle after DONE state).
  - Adds output busy (1 bit), high whenever the state is not IDLE.
- Undefined: neither port exists. S timing is identical in both builds.

Decomposition:
- Shared package mult_pkg:
  - State enum (IDLE, CALC, DONE) and its encoding.
  - Function computing counter width as clog2(M+1).
- One sub-module, mult_asmd_datapath: multiplicand, accumulator, multiplier and counter registers, the M+1-bit adder, and the shifter.
  - Control inputs: load, calc_step.
  - Status output: cnt_zero.
- The FSM controller and the S output register stay in the top.

Test Plan:
- Reset: hold reset_n=1 for 2 cycles with random inputs -> S=0, no activity; release -> S stays 0 until the first completion.
- M=5, A=12, B=11, start one cycle -> S=132 (10'b0010000100) after M+1 edges; S holds 132 afterwards.
- M=5, A=29, B=13 issued right after the previous result -> S=377 (10'h179). The previous value 132 persists until the update.
- Corners, M=5:
  - 31*31 -> 961.
  - 0*31 -> 0.
  - 31*1 -> 31.
  - 1*0 -> 0.
- Pulse start during CALC with different operands, and change A_in/B_in mid-operation -> the original product is unaffected and the second start is ignored.
- Assert reset_n=1 during CALC -> S=0 immediately. After release, a new start with 7*9 -> S=63 with normal latency; with MULT_DONE_EN, done pulses exactly once.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/mult_asmd_datapath.sv
// Datapath: operand registers, accumulator, iteration counter,
// (M+1)-bit adder and the combined right shifter.
module mult_asmd_datapath
   import mult_pkg::*;
#(
   parameter int M = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic           calc_step_i,
   input  logic [M-1:0]   a_i,
   input  logic [M-1:0]   b_i,
   output logic           cnt_zero_o,
   output logic [2*M-1:0] product_o
);

   localparam int CW = cnt_width(M);

   logic [M-1:0]  mcand_q;
   logic [M-1:0]  acc_q;
   logic [M-1:0]  mplr_q;
   logic [CW-1:0] cnt_q;
   logic [M:0]    addend;
   logic [M:0]    sum;

   assign addend = mplr_q[0] ? {1'b0, mcand_q} : '0;
   assign sum    = {1'b0, acc_q} + addend;

   // High on the final iteration: the counter hits 0 after this step.
   assign cnt_zero_o = (cnt_q == CW'(1));
   assign product_o  = {acc_q, mplr_q};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q <= '0;
         acc_q   <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else if (load_i) begin
         mcand_q <= a_i;
         mplr_q  <= b_i;
         acc_q   <= '0;
         cnt_q   <= CW'(M);
      end else if (calc_step_i) begin
         acc_q  <= sum[M:1];
         mplr_q <= {sum[0], mplr_q[M-1:1]};
         cnt_q  <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/mult4bit_asmd_top.sv
// ASMD-controlled unsigned shift-and-add multiplier, M+1 cycle latency.
// Optional MULT_DONE_EN adds done (one-cycle pulse) and busy outputs.
module mult4bit_asmd_top
   import mult_pkg::*;
#(
   parameter int M = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [M-1:0]   A_in,
   input  logic [M-1:0]   B_in,
   input  logic           start,
`ifdef MULT_DONE_EN
   output logic           done,
   output logic           busy,
`endif
   output logic [2*M-1:0] S
);

   state_e         state_q;
   state_e         state_d;
   logic           load;
   logic           calc_step;
   logic           cnt_zero;
   logic [2*M-1:0] product;
   logic [2*M-1:0] s_q;

   mult_asmd_datapath #(.M(M)) u_dp (
      .clk_i       (clk),
      .rst_i       (reset_n),
      .load_i      (load),
      .calc_step_i (calc_step),
      .a_i         (A_in),
      .b_i         (B_in),
      .cnt_zero_o  (cnt_zero),
      .product_o   (product)
   );

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      calc_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            calc_step = 1'b1;
            if (cnt_zero) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n)              s_q <= '0;
      else if (state_q == DONE) s_q <= product;
   end

   assign S = s_q;

`ifdef MULT_DONE_EN
   logic done_q;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) done_q <= 1'b0;
      else         done_q <= (state_q == DONE);
   end

   assign done = done_q;
   assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_mult4bit_asmd_top.sv
// Directed bench for mult4bit_asmd_top (M=5) with a latency-level model.
module tb_mult4bit_asmd_top;

   localparam int M = 5;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic [M-1:0]   A_in = '0;
   logic [M-1:0]   B_in = '0;
   logic           start = 1'b0;
   logic [2*M-1:0] S;
`ifdef MULT_DONE_EN
   logic           done;
   logic           busy;
   int             done_cnt = 0;
`endif

   int nvec = 0;
   int nerr = 0;

   mult4bit_asmd_top #(.M(M)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A_in    (A_in),
      .B_in    (B_in),
      .start   (start),
`ifdef MULT_DONE_EN
      .done    (done),
      .busy    (busy),
`endif
      .S       (S)
   );

   always #5 clk = ~clk;

   // Model: an accepted request publishes A*B M+1 edges later.
   int             m_left = 0;
   int             m_a = 0;
   int             m_b = 0;
   logic [2*M-1:0] exp_S = '0;
   logic           exp_done = 1'b0;

   always @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         m_left   = 0;
         exp_S    = '0;
         exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               exp_S    = (2*M)'(m_a * m_b);
               exp_done = 1'b1;
            end
         end else if (start) begin
            m_a    = int'(A_in);
            m_b    = int'(B_in);
            m_left = M + 1;
         end
      end
   end

   always @(negedge clk) begin
      nvec++;
      if (S !== exp_S) begin
         nerr++;
         $display("FAIL cycle_S: got %0d expected %0d at %0t", S, exp_S, $time);
      end
`ifdef MULT_DONE_EN
      nvec++;
      if (done !== exp_done || busy !== (m_left > 0)) begin
         nerr++;
         $display("FAIL cycle_done_busy: got %b%b expected %b%b at %0t",
                  done, busy, exp_done, (m_left > 0), $time);
      end
      if (done === 1'b1) done_cnt++;
`endif
   end

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one start; check S still holds prev just before the update
   // and equals the literal product right after it.
   task automatic run(input int a, input int b, input int prev, input int res);
      A_in  = M'(a);
      B_in  = M'(b);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A_in  = M'($urandom);
      B_in  = M'($urandom);
      repeat (5) @(negedge clk);
      chk($sformatf("hold_%0dx%0d", a, b), int'(S), prev);
      @(negedge clk);
      chk($sformatf("prod_%0dx%0d", a, b), int'(S), res);
   endtask

   initial begin
      reset_n = 1'b1;
      repeat (2) begin
         A_in  = M'($urandom);
         B_in  = M'($urandom);
         start = 1'($urandom);
         @(negedge clk);
      end
      chk("reset_S", int'(S), 0);
      start   = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", int'(S), 0);

      run(12, 11, 0, 132);
      run(29, 13, 132, 377);
      run(31, 31, 377, 961);
      run(0, 31, 961, 0);
      run(31, 1, 0, 31);
      run(1, 0, 31, 0);

      // Extra start during CALC plus operand changes must be ignored.
      A_in  = 5'd10;
      B_in  = 5'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A_in  = 5'd31;
      B_in  = 5'd31;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A_in  = 5'd7;
      repeat (4) @(negedge clk);
      chk("ignore_mid_start", int'(S), 30);
      repeat (3) @(negedge clk);
      chk("no_queued_start", int'(S), 30);

      // Start held high relaunches on each IDLE edge: 3*4 then 6*5.
      A_in  = 5'd3;
      B_in  = 5'd4;
      start = 1'b1;
      @(negedge clk);
      A_in  = 5'd6;
      B_in  = 5'd5;
      repeat (6) @(negedge clk);
      chk("held_start_1", int'(S), 12);
      repeat (7) @(negedge clk);
      chk("held_start_2", int'(S), 30);
      start = 1'b0;
      repeat (8) @(negedge clk);

      // Reset in CALC clears S at once, without waiting for a clock.
      A_in  = 5'd25;
      B_in  = 5'd25;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      #1 chk("async_reset_S", int'(S), 0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
`ifdef MULT_DONE_EN
      done_cnt = 0;
`endif
      run(7, 9, 0, 63);
      repeat (4) @(negedge clk);
      chk("after_reset_hold", int'(S), 63);
`ifdef MULT_DONE_EN
      chk("done_pulses", done_cnt, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
